// File: rtl/nd_1to2_pkg.sv
// Shared types and defaults for the nd_1to2 routing node.
package nd_1to2_pkg;

  localparam int unsigned NsAddressSize = 8;
  localparam int unsigned NsDataSize    = 8;

  // Input channel FSM
  typedef enum logic [1:0] {
    RxIdle,
    RxAck,
    RxWaitLow
  } rx_state_e;

  // Per-output channel FSM
  typedef enum logic [1:0] {
    TxIdle,
    TxReq,
    TxAcked
  } tx_state_e;

endpackage

// File: rtl/nd_1to2_if.sv
// Four-phase req/ack message channel carrying a destination address and data.
interface nd_1to2_if #(
  parameter int unsigned ASZ = nd_1to2_pkg::NsAddressSize,
  parameter int unsigned DSZ = nd_1to2_pkg::NsDataSize
) ();

  logic           req;
  logic           ack;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;

  modport master (output req, output dst, output dat, input ack);
  modport slave  (input req, input dst, input dat, output ack);

endinterface

// File: rtl/nd_1to2_out_buf.sv
// One-entry holding buffer feeding a four-phase output channel.
module nd_1to2_out_buf import nd_1to2_pkg::*; #(
  parameter int unsigned ASZ = NsAddressSize,
  parameter int unsigned DSZ = NsDataSize
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [ASZ-1:0] wr_dst,
  input  logic [DSZ-1:0] wr_dat,
  output logic           full,
  nd_1to2_if.master      snd
);

  tx_state_e      state_q;
  logic           full_q;
  logic [ASZ-1:0] buf_dst_q;
  logic [DSZ-1:0] buf_dat_q;
  logic           req_q;
  logic [ASZ-1:0] dst_q;
  logic [DSZ-1:0] dat_q;
  logic           tx_done;

  // The buffer frees up on the edge the downstream ack is seen, so it can be refilled then.
  assign tx_done = (state_q == TxReq) && snd.ack;
  assign full    = full_q && !tx_done;

  assign snd.req = req_q;
  assign snd.dst = dst_q;
  assign snd.dat = dat_q;

  // Buffer occupancy and contents; a fill wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      full_q    <= 1'b0;
      buf_dst_q <= '0;
      buf_dat_q <= '0;
    end else if (wr_en) begin
      full_q    <= 1'b1;
      buf_dst_q <= wr_dst;
      buf_dat_q <= wr_dat;
    end else if (tx_done) begin
      full_q <= 1'b0;
    end
  end

  // Output handshake FSM with registered req/dst/dat.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= TxIdle;
      req_q   <= 1'b0;
      dst_q   <= '0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        TxIdle: begin
          if (full_q) begin
            req_q   <= 1'b1;
            dst_q   <= buf_dst_q;
            dat_q   <= buf_dat_q;
            state_q <= TxReq;
          end
        end
        TxReq: begin
          if (snd.ack) begin
            req_q   <= 1'b0;
            state_q <= TxAcked;
          end
        end
        TxAcked: begin
          // Wait for ack low so req never re-rises under a stale ack.
          if (!snd.ack) state_q <= TxIdle;
        end
        default: state_q <= TxIdle;
      endcase
    end
  end

endmodule

// File: rtl/nd_1to2.sv
// 1-to-2 routing node: steers each input message to snd0 (dst <= REF_ADDR) or snd1.
module nd_1to2 import nd_1to2_pkg::*; #(
  parameter int unsigned    ASZ      = NsAddressSize,
  parameter int unsigned    DSZ      = NsDataSize,
  parameter logic [ASZ-1:0] REF_ADDR = '0
) (
  input  logic      i_clk,
  input  logic      reset,
  output logic      ready,
  nd_1to2_if.slave  rcv0,
  nd_1to2_if.master snd0,
  nd_1to2_if.master snd1
);

  rx_state_e state_q;
  logic      ack_q;
  logic      ready_q;
  logic      to_snd1;
  logic      full0;
  logic      full1;
  logic      target_full;
  logic      accept;

  assign to_snd1     = rcv0.dst > REF_ADDR;
  assign target_full = to_snd1 ? full1 : full0;
  assign accept      = (state_q == RxIdle) && rcv0.req && !target_full;

  assign rcv0.ack = ack_q;
  assign ready    = ready_q;

  // Input handshake FSM. Reset lands in RxWaitLow so a request held across reset
  // is never consumed; with req already low it falls through to RxIdle on the first edge.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= RxWaitLow;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        RxIdle: begin
          if (accept) begin
            ack_q   <= 1'b1;
            state_q <= RxAck;
          end
        end
        RxAck: begin
          if (!rcv0.req) begin
            ack_q   <= 1'b0;
            state_q <= RxIdle;
          end
        end
        RxWaitLow: begin
          if (!rcv0.req) state_q <= RxIdle;
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  nd_1to2_out_buf #(
    .ASZ(ASZ),
    .DSZ(DSZ)
  ) u_out0 (
    .i_clk (i_clk),
    .reset (reset),
    .wr_en (accept && !to_snd1),
    .wr_dst(rcv0.dst),
    .wr_dat(rcv0.dat),
    .full  (full0),
    .snd   (snd0)
  );

  nd_1to2_out_buf #(
    .ASZ(ASZ),
    .DSZ(DSZ)
  ) u_out1 (
    .i_clk (i_clk),
    .reset (reset),
    .wr_en (accept && to_snd1),
    .wr_dst(rcv0.dst),
    .wr_dat(rcv0.dat),
    .full  (full1),
    .snd   (snd1)
  );

endmodule

// File: tb/tb_nd_1to2.sv
// Directed bench for nd_1to2 with scoreboarded sinks on both outputs.
module tb_nd_1to2;

  localparam int unsigned ASZ     = 8;
  localparam int unsigned DSZ     = 8;
  localparam logic [7:0]  RefAddr = 8'd23;

  logic clk = 1'b0;
  logic rst_n;
  logic ready;

  nd_1to2_if #(.ASZ(ASZ), .DSZ(DSZ)) rcv0_if ();
  nd_1to2_if #(.ASZ(ASZ), .DSZ(DSZ)) snd0_if ();
  nd_1to2_if #(.ASZ(ASZ), .DSZ(DSZ)) snd1_if ();

  nd_1to2 #(
    .ASZ     (ASZ),
    .DSZ     (DSZ),
    .REF_ADDR(RefAddr)
  ) dut (
    .i_clk(clk),
    .reset(rst_n),
    .ready(ready),
    .rcv0 (rcv0_if),
    .snd0 (snd0_if),
    .snd1 (snd1_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  logic [15:0] got0[$];
  logic [15:0] got1[$];

  bit hold0 = 1'b0;
  bit hold1 = 1'b0;
  bit rnd   = 1'b0;
  int viol  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sink for snd0: acks after a delay, releases ack once req drops.
  initial begin
    int cnt = 0;
    int dly = 0;
    snd0_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (snd0_if.ack) begin
        if (!snd0_if.req) snd0_if.ack = 1'b0;
      end else if (snd0_if.req && !hold0) begin
        if (cnt >= dly) begin
          got0.push_back({snd0_if.dst, snd0_if.dat});
          snd0_if.ack = 1'b1;
          cnt = 0;
          dly = rnd ? int'($urandom_range(0, 7)) : 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Sink for snd1.
  initial begin
    int cnt = 0;
    int dly = 0;
    snd1_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (snd1_if.ack) begin
        if (!snd1_if.req) snd1_if.ack = 1'b0;
      end else if (snd1_if.req && !hold1) begin
        if (cnt >= dly) begin
          got1.push_back({snd1_if.dst, snd1_if.dat});
          snd1_if.ack = 1'b1;
          cnt = 0;
          dly = rnd ? int'($urandom_range(0, 7)) : 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Flags any req that rises while the matching ack is still high.
  initial begin
    bit p0 = 1'b0;
    bit p1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (snd0_if.req && !p0 && snd0_if.ack) viol++;
      if (snd1_if.req && !p1 && snd1_if.ack) viol++;
      p0 = snd0_if.req;
      p1 = snd1_if.req;
    end
  end

  task automatic wait_rx_ack(input logic val, input string tag);
    int n = 0;
    while (rcv0_if.ack !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rcv0_if.ack !== val) check(tag, rcv0_if.ack, val);
  endtask

  task automatic rx_start(input logic [7:0] d, input logic [7:0] t);
    wait_rx_ack(1'b0, "rx_idle_timeout");
    rcv0_if.dst = d;
    rcv0_if.dat = t;
    rcv0_if.req = 1'b1;
    if (d > RefAddr) exp1.push_back({d, t});
    else             exp0.push_back({d, t});
  endtask

  task automatic rx_finish();
    wait_rx_ack(1'b1, "rx_ack_timeout");
    rcv0_if.req = 1'b0;
    wait_rx_ack(1'b0, "rx_release_timeout");
  endtask

  task automatic drain_and_compare(input string tag);
    repeat (40) @(negedge clk);
    check({tag, "_n0"}, got0.size(), exp0.size());
    check({tag, "_n1"}, got1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      check({tag, "_snd0"}, {16'h0, got0[i]}, {16'h0, exp0[i]});
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      check({tag, "_snd1"}, {16'h0, got1[i]}, {16'h0, exp1[i]});
    exp0.delete();
    exp1.delete();
    got0.delete();
    got1.delete();
  endtask

  initial begin
    logic [7:0] vdst[4];
    logic [7:0] vdat[4];
    bit         vside[4];
    logic       treq;
    logic [7:0] tdst;
    logic [7:0] tdat;
    logic [7:0] rd;
    logic [7:0] rt;

    vdst  = '{8'd23, 8'd24, 8'd255, 8'd0};
    vdat  = '{8'h05, 8'h06, 8'h07, 8'h08};
    vside = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with a stale request pending.
    rst_n       = 1'b0;
    rcv0_if.req = 1'b1;
    rcv0_if.dst = 8'd3;
    rcv0_if.dat = 8'h99;
    repeat (5) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_rx_ack", rcv0_if.ack, 1'b0);
    check("rst_snd0_req", snd0_if.req, 1'b0);
    check("rst_snd1_req", snd1_if.req, 1'b0);
    check("rst_snd0_dst", snd0_if.dst, 8'd0);
    check("rst_snd1_dat", snd1_if.dat, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_rise", ready, 1'b1);
    repeat (3) @(negedge clk);
    check("stale_no_ack", rcv0_if.ack, 1'b0);
    check("stale_no_snd0", snd0_if.req, 1'b0);
    check("stale_no_snd1", snd1_if.req, 1'b0);
    rcv0_if.req = 1'b0;
    repeat (2) @(negedge clk);

    // Routing boundaries and two-cycle latency.
    for (int i = 0; i < 4; i++) begin
      rx_start(vdst[i], vdat[i]);
      @(negedge clk);
      check("lat_rx_ack", rcv0_if.ack, 1'b1);
      treq = vside[i] ? snd1_if.req : snd0_if.req;
      check("lat_req_early", treq, 1'b0);
      rcv0_if.req = 1'b0;
      @(negedge clk);
      treq = vside[i] ? snd1_if.req : snd0_if.req;
      tdst = vside[i] ? snd1_if.dst : snd0_if.dst;
      tdat = vside[i] ? snd1_if.dat : snd0_if.dat;
      check("lat_req", treq, 1'b1);
      check("lat_dst", tdst, vdst[i]);
      check("lat_dat", tdat, vdat[i]);
      wait_rx_ack(1'b0, "lat_release_timeout");
      repeat (3) @(negedge clk);
    end
    drain_and_compare("route");

    // Backpressure: B waits behind A on a stalled snd0.
    hold0 = 1'b1;
    rx_start(8'd3, 8'hA1);
    rx_finish();
    rx_start(8'd4, 8'hB2);
    repeat (10) @(negedge clk);
    check("bp_b_no_ack", rcv0_if.ack, 1'b0);
    check("bp_a_held_req", snd0_if.req, 1'b1);
    check("bp_a_held_dst", snd0_if.dst, 8'd3);
    hold0 = 1'b0;
    rx_finish();
    rx_start(8'd40, 8'hC3);
    rx_finish();
    drain_and_compare("bp");

    // Independent outputs: snd1 traffic flows while snd0 is stalled.
    hold0 = 1'b1;
    rx_start(8'd5, 8'h15);
    rx_finish();
    rx_start(8'd50, 8'h32);
    rx_finish();
    repeat (10) @(negedge clk);
    check("ind_snd1_delivered", got1.size(), 1);
    check("ind_snd0_stalled", got0.size(), 0);
    check("ind_snd0_req", snd0_if.req, 1'b1);
    hold0 = 1'b0;
    rx_start(8'd6, 8'h16);
    rx_finish();
    rx_start(8'd51, 8'h33);
    rx_finish();
    drain_and_compare("ind");

    // Reset in the middle of live handshakes on both sides.
    hold1 = 1'b1;
    rx_start(8'd30, 8'h1E);
    rx_finish();
    rx_start(8'd10, 8'h0A);
    wait_rx_ack(1'b1, "mr_ack_timeout");
    check("mr_pre_snd1_req", snd1_if.req, 1'b1);
    check("mr_pre_rx_ack", rcv0_if.ack, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_snd1_req_drop", snd1_if.req, 1'b0);
    check("mr_rx_ack_drop", rcv0_if.ack, 1'b0);
    check("mr_snd0_req", snd0_if.req, 1'b0);
    check("mr_snd1_dst_clr", snd1_if.dst, 8'd0);
    check("mr_ready_drop", ready, 1'b0);
    rcv0_if.req = 1'b0;
    hold1 = 1'b0;
    exp0.delete();
    exp1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rx_start(8'd0, 8'h01);
    rx_finish();
    drain_and_compare("mr");

    // Random stream with random sink delays.
    rnd = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rd = 8'($urandom());
      rt = 8'($urandom());
      rx_start(rd, rt);
      rx_finish();
    end
    drain_and_compare("stream");
    check("no_req_under_ack", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
